// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register/data widths, write-back source
// encoding and the write-back request payload.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_LU   = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle.
// Inputs to the arbiter: pipeline write-back request, long-latency result
// (valid/ready), issue notification. Outputs: register file write port,
// write source, busy-register scoreboard, stall request.
interface wb_arbiter_if;
  import mips_pkg::*;

  logic                  pipe_wb_valid;
  logic [REG_ADDR_W-1:0] pipe_wb_addr;
  logic [DATA_W-1:0]     pipe_wb_data;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0]     lu_data;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;

  logic                  reg_write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;
  wb_src_t               wb_src;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  stall_req;

  // Arbiter side
  modport slave (
    input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
    input  lu_valid, lu_addr, lu_data,
    input  issue_valid, issue_addr,
    output lu_ready,
    output reg_write_en, write_addr, write_data, wb_src, busy_mask, stall_req
  );

  // Pipeline / long-latency unit / decode side
  modport master (
    output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
    output lu_valid, lu_addr, lu_data,
    output issue_valid, issue_addr,
    input  lu_ready,
    input  reg_write_en, write_addr, write_data, wb_src, busy_mask, stall_req
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests with wrap-around pointers and an
// occupancy counter. Synchronous flush on rst.
// Ports: clk, rst, push_i/push_data_i (ignored when full), pop_i (ignored
// when empty), head_o (current head entry), full_o, empty_o.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full blocks push even when a pop frees a slot in the same cycle
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer/occupancy next state; DEPTH is a power of two so pointers wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: flushing the pointers invalidates it
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle pipeline write-back stream with
// buffered long-latency results onto the one register file write port,
// tracks outstanding long-latency destinations and requests a write-back
// bubble when a buffered result starves.
// Ports: clk, rst (sync, active-high), bus (wb_arbiter_if.slave: pipeline
// request, long-latency valid/ready, issue, registered write port, wb_src,
// busy_mask, stall_req).
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic                  pipe_live;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  wb_req_t               head;
  wb_req_t               push_req;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  wb_src_t               src_q, src_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  stall_q, stall_d;

  assign pipe_live     = bus.pipe_wb_valid && (bus.pipe_wb_addr != '0);
  assign bus.lu_ready  = !rst && !fifo_full;
  // Address-0 results complete the handshake but are dropped
  assign push          = bus.lu_valid && bus.lu_ready && (bus.lu_addr != '0);
  assign pop           = !pipe_live && !fifo_empty;
  assign push_req.addr = bus.lu_addr;
  assign push_req.data = bus.lu_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Port selection, scoreboard and starvation next state
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    src_d   = WB_SRC_NONE;
    busy_d  = busy_q;
    wait_d  = wait_q;
    stall_d = 1'b0;

    if (pipe_live) begin
      we_d   = 1'b1;
      addr_d = bus.pipe_wb_addr;
      data_d = bus.pipe_wb_data;
      src_d  = WB_SRC_PIPE;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = head.addr;
      data_d = head.data;
      src_d  = WB_SRC_LU;
    end

    // Clear first so a same-cycle issue to the same register wins
    if (pop) busy_d[head.addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != '0)) busy_d[bus.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;

    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Trails the saturated counter by one cycle; drops right after a pop
    stall_d = (wait_q == WAIT_W'(STARVE_LIMIT)) && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= WB_SRC_NONE;
      busy_q  <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign bus.reg_write_en = we_q;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  assign bus.wb_src       = src_q;
  assign bus.busy_mask    = busy_q;
  assign bus.stall_req    = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with constant
// expectations plus randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  wb_req_t     mq[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_src;
  int          m_wait;
  logic        m_stall;

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ia);
    bus.pipe_wb_valid = pv; bus.pipe_wb_addr = pa; bus.pipe_wb_data = pd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
    bus.issue_valid = iv; bus.issue_addr = ia;
  endtask

  // One clock of the behavioural model, applied to the currently driven inputs
  task automatic model_step();
    wb_req_t h;
    bit live, pop, ready, was_empty;
    if (rst) begin
      mq.delete(); m_busy = '0; m_we = 0; m_addr = '0; m_data = '0;
      m_src = 2'd0; m_wait = 0; m_stall = 0;
      return;
    end
    live      = bus.pipe_wb_valid && bus.pipe_wb_addr != 0;
    ready     = mq.size() < DEPTH;
    was_empty = mq.size() == 0;
    pop       = !live && !was_empty;
    if (!was_empty) h = mq[0];
    m_stall = (m_wait == LIMIT) && !pop;
    if (live) begin
      m_we = 1; m_addr = bus.pipe_wb_addr; m_data = bus.pipe_wb_data; m_src = 2'd1;
    end else if (pop) begin
      m_we = 1; m_addr = h.addr; m_data = h.data; m_src = 2'd2;
    end else begin
      m_we = 0; m_src = 2'd0;
    end
    if (pop) begin
      m_busy[h.addr] = 1'b0;
      void'(mq.pop_front());
    end
    if (bus.issue_valid && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
    if (bus.lu_valid && ready && bus.lu_addr != 0) mq.push_back({bus.lu_addr, bus.lu_data});
    if (was_empty || pop) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5'd3, $urandom, 1, 5'd4, $urandom, 1, 5'd6);
    #1;
    if (bus.lu_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", bus.lu_ready); n_bad++; end
    n_vec++;
    tick(); tick();
    if ({bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src), bus.busy_mask, bus.stall_req} !== 73'd0) begin
      $display("FAIL reset_state: we=%b a=%0d d=%h src=%0d busy=%h stall=%b want all zero",
               bus.reg_write_en, bus.write_addr, bus.write_data, bus.wb_src, bus.busy_mask, bus.stall_req);
      n_bad++;
    end
    n_vec++;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if (bus.lu_ready !== 1'b1) begin $display("FAIL reset_release_ready: got %b want 1", bus.lu_ready); n_bad++; end
    n_vec++;
  endtask

  task automatic test_pipe_write();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    if ({bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src)} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd1}) begin
      $display("FAIL pipe_write: we=%b a=%0d d=%h src=%0d want 1/5/deadbeef/1",
               bus.reg_write_en, bus.write_addr, bus.write_data, bus.wb_src);
      n_bad++;
    end
    n_vec++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if ({bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src)} !== {1'b0, 5'd5, 32'hDEADBEEF, 2'd0}) begin
      $display("FAIL pipe_idle_hold: we=%b a=%0d d=%h src=%0d want 0/5/deadbeef/0",
               bus.reg_write_en, bus.write_addr, bus.write_data, bus.wb_src);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_addr0();
    drive(0, 0, 0, 1, 5'd9, 32'h1234, 0, 0);
    tick();
    drive(1, 5'd0, 32'hBAD0BAD0, 0, 0, 0, 0, 0);
    tick();
    if ({bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src)} !== {1'b1, 5'd9, 32'h1234, 2'd2}) begin
      $display("FAIL addr0_ignored: we=%b a=%0d d=%h src=%0d want 1/9/1234/2",
               bus.reg_write_en, bus.write_addr, bus.write_data, bus.wb_src);
      n_bad++;
    end
    n_vec++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_deferred();
    drive(1, 5'd3, 32'h3, 1, 5'd9, 32'h1234, 1, 5'd9);
    tick();
    if (bus.busy_mask[9] !== 1'b1) begin $display("FAIL defer_busy_set: got %b want 1", bus.busy_mask[9]); n_bad++; end
    n_vec++;
    for (int k = 0; k < 2; k++) begin
      drive(1, 5'(4 + k), 32'(k), 0, 0, 0, 0, 0);
      tick();
      if ({2'(bus.wb_src), bus.busy_mask[9]} !== {2'd1, 1'b1}) begin
        $display("FAIL defer_pipe_wins[%0d]: src=%0d busy9=%b want 1/1", k, bus.wb_src, bus.busy_mask[9]);
        n_bad++;
      end
      n_vec++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if ({bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src), bus.busy_mask[9]} !== {1'b1, 5'd9, 32'h1234, 2'd2, 1'b0}) begin
      $display("FAIL defer_lu_write: we=%b a=%0d d=%h src=%0d busy9=%b want 1/9/1234/2/0",
               bus.reg_write_en, bus.write_addr, bus.write_data, bus.wb_src, bus.busy_mask[9]);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_full();
    drive(1, 5'd1, 32'h1, 1, 5'd10, 32'hA, 0, 0);
    tick();
    drive(1, 5'd1, 32'h1, 1, 5'd11, 32'hB, 0, 0);
    tick();
    if (bus.lu_ready !== 1'b0) begin $display("FAIL full_ready: got %b want 0", bus.lu_ready); n_bad++; end
    n_vec++;
    drive(1, 5'd1, 32'h1, 1, 5'd12, 32'hC, 0, 0);
    tick();
    if (bus.lu_ready !== 1'b0) begin $display("FAIL full_held: got %b want 0", bus.lu_ready); n_bad++; end
    n_vec++;
    drive(0, 0, 0, 1, 5'd12, 32'hC, 0, 0);
    tick();
    if ({bus.write_addr, bus.write_data, 2'(bus.wb_src), bus.lu_ready} !== {5'd10, 32'hA, 2'd2, 1'b1}) begin
      $display("FAIL full_drain0: a=%0d d=%h src=%0d ready=%b want 10/a/2/1",
               bus.write_addr, bus.write_data, bus.wb_src, bus.lu_ready);
      n_bad++;
    end
    n_vec++;
    tick();
    if ({bus.write_addr, bus.write_data, 2'(bus.wb_src)} !== {5'd11, 32'hB, 2'd2}) begin
      $display("FAIL full_drain1: a=%0d d=%h src=%0d want 11/b/2", bus.write_addr, bus.write_data, bus.wb_src);
      n_bad++;
    end
    n_vec++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if ({bus.write_addr, bus.write_data, 2'(bus.wb_src)} !== {5'd12, 32'hC, 2'd2}) begin
      $display("FAIL full_drain2: a=%0d d=%h src=%0d want 12/c/2", bus.write_addr, bus.write_data, bus.wb_src);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_starvation();
    drive(1, 5'd2, 32'h2, 1, 5'd13, 32'hD, 0, 0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      drive(1, 5'd2, 32'(t), 0, 0, 0, 0, 0);
      if (bus.stall_req !== (t >= 6)) begin
        $display("FAIL starve_stall[t=%0d]: got %b want %b", t, bus.stall_req, (t >= 6));
        n_bad++;
      end
      n_vec++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if ({bus.write_addr, 2'(bus.wb_src), bus.stall_req} !== {5'd13, 2'd2, 1'b0}) begin
      $display("FAIL starve_release: a=%0d src=%0d stall=%b want 13/2/0", bus.write_addr, bus.wb_src, bus.stall_req);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_set_wins_flush();
    drive(1, 5'd2, 32'h2, 1, 5'd7, 32'h77, 1, 5'd7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7);
    tick();
    if ({bus.write_addr, 2'(bus.wb_src), bus.busy_mask[7]} !== {5'd7, 2'd2, 1'b1}) begin
      $display("FAIL set_wins: a=%0d src=%0d busy7=%b want 7/2/1", bus.write_addr, bus.wb_src, bus.busy_mask[7]);
      n_bad++;
    end
    n_vec++;
    drive(1, 5'd3, 32'h3, 1, 5'd14, 32'hE, 1, 5'd14);
    tick();
    drive(1, 5'd3, 32'h3, 1, 5'd15, 32'hF, 0, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    if (bus.lu_ready !== 1'b0) begin $display("FAIL flush_ready: got %b want 0", bus.lu_ready); n_bad++; end
    n_vec++;
    tick();
    rst = 1'b0;
    if ({bus.reg_write_en, 2'(bus.wb_src), bus.busy_mask} !== {1'b0, 2'd0, 32'd0}) begin
      $display("FAIL flush_state: we=%b src=%0d busy=%h want 0/0/0", bus.reg_write_en, bus.wb_src, bus.busy_mask);
      n_bad++;
    end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({bus.reg_write_en, bus.busy_mask} !== 33'd0) begin
        $display("FAIL flush_no_write[%0d]: we=%b a=%0d busy=%h want 0/-/0", k, bus.reg_write_en, bus.write_addr, bus.busy_mask);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_random();
    logic [72:0] got, want;
    int pv_pct;
    pv_pct = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) pv_pct = (i % 150 == 0) ? 20 : ((i % 150 == 50) ? 95 : 60);
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 99) < pv_pct, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
      #1;
      if (bus.lu_ready !== (!rst && mq.size() < DEPTH)) begin
        $display("FAIL rand_ready[%0d]: got %b want %b", i, bus.lu_ready, (!rst && mq.size() < DEPTH));
        n_bad++;
      end
      n_vec++;
      tick();
      got  = {bus.reg_write_en, bus.write_addr, bus.write_data, 2'(bus.wb_src), bus.busy_mask, bus.stall_req};
      want = {m_we, m_addr, m_data, m_src, m_busy, m_stall};
      if (got !== want) begin
        $display("FAIL rand_out[%0d]: got we/a/d/src/busy/stall=%h want %h", i, got, want);
        n_bad++;
      end
      n_vec++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_addr0();
    test_deferred();
    test_full();
    test_starvation();
    test_set_wins_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
